crc8_frame_checker: RTL

CRC8_FRAME_CHECKER -- requirements
Module: crc8_frame_checker

---
 rtl/crc8_frame_checker.sv | 130 +++++++++++++
 1 files changed

// File: rtl/crc8_frame_checker.sv
// rtl/crc8_frame_checker.sv - bit-serial CRC-8 frame checker with held result
//
// Purpose:
//   Accepts a byte stream. The trailing CRC byte is part of the stream and is
//   marked by s_last. Each accepted byte is folded into the CRC register and
//   then shifted one bit per cycle for 8 cycles. After the last byte the
//   verdict (remainder zero) and the frame length are held until consumed.
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   s_valid    byte-stream valid
//   s_ready    byte-stream ready (high only while accepting)
//   s_data     frame byte, including the received CRC byte
//   s_last     final byte of the frame
//   res_valid  frame result available
//   res_ready  result consumer ready
//   res_ok     1 = CRC remainder zero (0 while res_valid is low)
//   res_len    saturating frame byte count (0 while res_valid is low)
//   busy       high unless idle in ACCEPT with no bytes of a frame taken
module crc8_frame_checker #(
    parameter logic [7:0] POLYNOMIAL = 8'h07,
    parameter logic [7:0] INIT       = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [7:0] s_data,
    input  logic       s_last,
    output logic       res_valid,
    input  logic       res_ready,
    output logic       res_ok,
    output logic [7:0] res_len,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_RESULT = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [7:0] crc;
    logic [7:0] crc_nx;
    logic [7:0] byte_cnt;
    logic [7:0] byte_cnt_nx;
    logic [2:0] shift_cnt;
    logic [2:0] shift_cnt_nx;
    logic       last_flag;
    logic       last_flag_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_ACCEPT;
            crc       <= INIT;
            byte_cnt  <= 8'd0;
            shift_cnt <= 3'd0;
            last_flag <= 1'b0;
        end else begin
            state     <= state_nx;
            crc       <= crc_nx;
            byte_cnt  <= byte_cnt_nx;
            shift_cnt <= shift_cnt_nx;
            last_flag <= last_flag_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        crc_nx       = crc;
        byte_cnt_nx  = byte_cnt;
        shift_cnt_nx = shift_cnt;
        last_flag_nx = last_flag;
        s_ready      = 1'b0;
        res_valid    = 1'b0;
        res_ok       = 1'b0;
        res_len      = 8'd0;
        busy         = 1'b1;

        case (state)
            ST_ACCEPT: begin
                s_ready = 1'b1;
                // Between bytes of a frame the block is still mid-frame.
                busy    = (byte_cnt != 8'd0);
                if (s_valid) begin
                    crc_nx       = crc ^ s_data;
                    last_flag_nx = s_last;
                    shift_cnt_nx = 3'd0;
                    if (byte_cnt != 8'hFF) begin
                        byte_cnt_nx = byte_cnt + 8'd1;
                    end
                    state_nx = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (crc[7]) begin
                    crc_nx = {crc[6:0], 1'b0} ^ POLYNOMIAL;
                end else begin
                    crc_nx = {crc[6:0], 1'b0};
                end
                shift_cnt_nx = shift_cnt + 3'd1;
                // shift_cnt == 7 marks the 8th and final step for this byte.
                if (shift_cnt == 3'd7) begin
                    state_nx = last_flag ? ST_RESULT : ST_ACCEPT;
                end
            end

            ST_RESULT: begin
                res_valid = 1'b1;
                res_ok    = (crc == 8'h00);
                res_len   = byte_cnt;
                if (res_ready) begin
                    crc_nx       = INIT;
                    byte_cnt_nx  = 8'd0;
                    last_flag_nx = 1'b0;
                    state_nx     = ST_ACCEPT;
                end
            end

            default: begin
                state_nx = ST_ACCEPT;
            end
        endcase
    end

endmodule
